// File: rtl/fcmp_pipe_if.sv
// Operand/result bundle for the pipelined FP compare unit (fcmp_pipe).
// Handshake: a beat moves on a side when valid && ready at a rising clk edge; the sender holds
//   its payload stable while valid && !ready, and valid never depends on ready.
interface fcmp_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [W-1:0]     in_x1;
  logic [W-1:0]     in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic             out_nv;
  logic [W-1:0]     out_res;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_nv, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_nv, out_res, out_tag
  );
endinterface

// File: rtl/fcmp_pipe.sv
// Elastic pipelined FEQ/FLT/FLE unit with RISC-V invalid flagging; stage 0 computes, later stages delay.
// Optional FMIN/FMAX (ops 3/4) is enabled by defining FCMP_MINMAX_EN.
module fcmp_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input logic       clk,
  input logic       rstn,
  fcmp_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] OP_FEQ = 3'd0;
  localparam logic [2:0] OP_FLT = 3'd1;
  localparam logic [2:0] OP_FLE = 3'd2;
`ifdef FCMP_MINMAX_EN
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`endif

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("fcmp_pipe: LATENCY must be in 1..4");
  end

  logic             w_s1, w_s2;
  logic             w_nan1, w_nan2, w_snan1, w_snan2, w_zero1, w_zero2;
  logic             w_any_nan, w_any_snan, w_both_zero, w_eq, w_lt;
  logic             w_y, w_nv;
  logic [W-1:0]     w_res;
  logic [LATENCY-1:0] w_load;

  logic [LATENCY-1:0] r_v;
  logic               r_y   [LATENCY];
  logic               r_nv  [LATENCY];
  logic [W-1:0]       r_res [LATENCY];
  logic [TAG_W-1:0]   r_tag [LATENCY];

  assign w_s1    = bus.in_x1[W-1];
  assign w_s2    = bus.in_x2[W-1];
  assign w_nan1  = (&bus.in_x1[W-2:MAN_W]) && (|bus.in_x1[MAN_W-1:0]);
  assign w_nan2  = (&bus.in_x2[W-2:MAN_W]) && (|bus.in_x2[MAN_W-1:0]);
  assign w_snan1 = w_nan1 && !bus.in_x1[MAN_W-1];
  assign w_snan2 = w_nan2 && !bus.in_x2[MAN_W-1];
  assign w_zero1 = ~|bus.in_x1[W-2:0];
  assign w_zero2 = ~|bus.in_x2[W-2:0];

  assign w_any_nan   = w_nan1 || w_nan2;
  assign w_any_snan  = w_snan1 || w_snan2;
  assign w_both_zero = w_zero1 && w_zero2;
  assign w_eq        = (bus.in_x1 == bus.in_x2);

  // Sign-magnitude order: -0 sorts below +0 here; callers handle the both-zero case themselves.
  always_comb begin
    w_lt = 1'b0;
    if (w_s1 != w_s2)  w_lt = w_s1;
    else if (w_s1)     w_lt = (bus.in_x2[W-2:0] < bus.in_x1[W-2:0]);
    else               w_lt = (bus.in_x1[W-2:0] < bus.in_x2[W-2:0]);
  end

  always_comb begin
    w_y   = 1'b0;
    w_nv  = 1'b0;
    w_res = '0;
    case (bus.in_op)
      OP_FEQ: begin
        w_nv = w_any_snan;
        if (w_any_nan)        w_y = 1'b0;
        else if (w_both_zero) w_y = 1'b1;
        else                  w_y = w_eq;
      end
      OP_FLT, OP_FLE: begin
        if (w_any_nan) begin
          w_nv = 1'b1;
        end else if (w_both_zero) begin
          w_y = (bus.in_op == OP_FLE);
        end else begin
          w_y = w_lt || ((bus.in_op == OP_FLE) && w_eq);
        end
      end
`ifdef FCMP_MINMAX_EN
      OP_FMIN, OP_FMAX: begin
        w_nv = w_any_snan;
        if (w_nan1 && w_nan2)         w_res = QNAN;
        else if (w_nan1)              w_res = bus.in_x2;
        else if (w_nan2)              w_res = bus.in_x1;
        else if (bus.in_op == OP_FMIN) w_res = w_lt ? bus.in_x1 : bus.in_x2;
        else                          w_res = w_lt ? bus.in_x2 : bus.in_x1;
      end
`endif
      default: ;
    endcase
  end

  // Stage k may load if any stage at or after it is empty, or the consumer is taking the output.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < LATENCY; k++) begin
      w_load[k] = bus.out_ready;
      for (int j = k; j < LATENCY; j++) begin
        if (!r_v[j]) w_load[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_y[k]   <= 1'b0;
        r_nv[k]  <= 1'b0;
        r_res[k] <= '0;
        r_tag[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_v[0]   <= bus.in_valid;
        r_y[0]   <= w_y;
        r_nv[0]  <= w_nv;
        r_res[0] <= w_res;
        r_tag[0] <= bus.in_tag;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (w_load[k]) begin
          r_v[k]   <= r_v[k-1];
          r_y[k]   <= r_y[k-1];
          r_nv[k]  <= r_nv[k-1];
          r_res[k] <= r_res[k-1];
          r_tag[k] <= r_tag[k-1];
        end
      end
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_v[LATENCY-1];
  assign bus.out_y     = r_y[LATENCY-1];
  assign bus.out_nv    = r_nv[LATENCY-1];
  assign bus.out_res   = r_res[LATENCY-1];
  assign bus.out_tag   = r_tag[LATENCY-1];
endmodule
